id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard stall, flush and operand forwarding selects.
// Define FORWARDING_EN for EX/MEM and MEM/WB forwarding; otherwise any in-flight producer stalls ID.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CTRLW = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_id_valid,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_regwrite,
  input  logic             i_id_memread,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic [XLEN-1:0]  i_id_imm,
  input  logic [CTRLW-1:0] i_id_ctrl,
  input  logic [XLEN-1:0]  i_rf_rdata1,
  input  logic [XLEN-1:0]  i_rf_rdata2,
  input  logic [4:0]       i_exmem_rd,
  input  logic             i_exmem_regwrite,
  input  logic [4:0]       i_memwb_rd,
  input  logic             i_memwb_regwrite,
  input  logic             i_flush,
  output logic             o_id_stall,
  output logic             o_ex_valid,
  output logic             o_ex_regwrite,
  output logic             o_ex_memread,
  output logic [4:0]       o_ex_rs1,
  output logic [4:0]       o_ex_rs2,
  output logic [4:0]       o_ex_rd,
  output logic [XLEN-1:0]  o_ex_op1,
  output logic [XLEN-1:0]  o_ex_op2,
  output logic [XLEN-1:0]  o_ex_imm,
  output logic [CTRLW-1:0] o_ex_ctrl,
  output logic [1:0]       o_ex_fwd_a,
  output logic [1:0]       o_ex_fwd_b,
  output logic [31:0]      o_stall_count
);

  logic             r_ex_valid, r_ex_regwrite, r_ex_memread;
  logic [4:0]       r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic [XLEN-1:0]  r_ex_op1, r_ex_op2, r_ex_imm;
  logic [CTRLW-1:0] r_ex_ctrl;
  logic [31:0]      r_stall_count;
  logic             w_hazard, w_id_stall;
  logic [1:0]       w_fwd_a, w_fwd_b;

  // x0 is hardwired, so a zero index never creates a dependency
  function automatic logic f_match(input logic used, input logic [4:0] src,
                                   input logic [4:0] prod_rd, input logic prod_we);
    return used && (src != 5'd0) && (src == prod_rd) && prod_we;
  endfunction

  function automatic logic f_id_hit(input logic [4:0] prod_rd, input logic prod_we);
    return f_match(i_id_use_rs1, i_id_rs1, prod_rd, prod_we) ||
           f_match(i_id_use_rs2, i_id_rs2, prod_rd, prod_we);
  endfunction

  always_comb begin
    w_hazard = f_id_hit(r_ex_rd, r_ex_valid && r_ex_memread);
    w_fwd_a  = 2'b00;
    w_fwd_b  = 2'b00;
`ifdef FORWARDING_EN
    if (r_ex_valid) begin
      if (f_match(1'b1, r_ex_rs1, i_exmem_rd, i_exmem_regwrite))      w_fwd_a = 2'b10;
      else if (f_match(1'b1, r_ex_rs1, i_memwb_rd, i_memwb_regwrite)) w_fwd_a = 2'b01;
      if (f_match(1'b1, r_ex_rs2, i_exmem_rd, i_exmem_regwrite))      w_fwd_b = 2'b10;
      else if (f_match(1'b1, r_ex_rs2, i_memwb_rd, i_memwb_regwrite)) w_fwd_b = 2'b01;
    end
`else
    // WB producers are covered by the negedge register-file write
    w_hazard = w_hazard || f_id_hit(r_ex_rd, r_ex_valid && r_ex_regwrite) ||
               f_id_hit(i_exmem_rd, i_exmem_regwrite);
`endif
    w_id_stall = i_id_valid && w_hazard && !i_flush;
  end

`ifndef FORWARDING_EN
  logic w_unused_memwb;
  assign w_unused_memwb = ^{i_memwb_rd, i_memwb_regwrite};
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_op1      <= '0;
      r_ex_op2      <= '0;
      r_ex_imm      <= '0;
      r_ex_ctrl     <= '0;
    end else if (i_flush || w_id_stall) begin
      // kill and bubble both load an all-zero entry
      r_ex_valid    <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_memread  <= 1'b0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_op1      <= '0;
      r_ex_op2      <= '0;
      r_ex_imm      <= '0;
      r_ex_ctrl     <= '0;
    end else begin
      r_ex_valid    <= i_id_valid;
      r_ex_regwrite <= i_id_valid && i_id_regwrite;
      r_ex_memread  <= i_id_valid && i_id_memread;
      r_ex_rs1      <= i_id_rs1;
      r_ex_rs2      <= i_id_rs2;
      r_ex_rd       <= i_id_rd;
      r_ex_op1      <= i_rf_rdata1;
      r_ex_op2      <= i_rf_rdata2;
      r_ex_imm      <= i_id_imm;
      r_ex_ctrl     <= i_id_ctrl;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_stall_count <= '0;
    else if (w_id_stall && (r_stall_count != 32'hFFFF_FFFF)) r_stall_count <= r_stall_count + 32'd1;
  end

  assign o_id_stall    = w_id_stall;
  assign o_ex_valid    = r_ex_valid;
  assign o_ex_regwrite = r_ex_regwrite;
  assign o_ex_memread  = r_ex_memread;
  assign o_ex_rs1      = r_ex_rs1;
  assign o_ex_rs2      = r_ex_rs2;
  assign o_ex_rd       = r_ex_rd;
  assign o_ex_op1      = r_ex_op1;
  assign o_ex_op2      = r_ex_op2;
  assign o_ex_imm      = r_ex_imm;
  assign o_ex_ctrl     = r_ex_ctrl;
  assign o_ex_fwd_a    = w_fwd_a;
  assign o_ex_fwd_b    = w_fwd_b;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and random checks of id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;
  localparam int XLEN  = 64;
  localparam int CTRLW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             id_valid, use1, use2, id_rw, id_mr;
  logic [4:0]       rs1, rs2, rd;
  logic [XLEN-1:0]  imm, rd1, rd2;
  logic [CTRLW-1:0] ctrl;
  logic [4:0]       exmem_rd, memwb_rd;
  logic             exmem_we, memwb_we, flush;
  logic             id_stall, ex_valid, ex_rw, ex_mr;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]  ex_op1, ex_op2, ex_imm;
  logic [CTRLW-1:0] ex_ctrl;
  logic [1:0]       fwd_a, fwd_b;
  logic [31:0]      stall_count;

  id_ex_stage #(.XLEN(XLEN), .CTRLW(CTRLW)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_id_valid(id_valid), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_regwrite(id_rw), .i_id_memread(id_mr),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(rd),
    .i_id_imm(imm), .i_id_ctrl(ctrl), .i_rf_rdata1(rd1), .i_rf_rdata2(rd2),
    .i_exmem_rd(exmem_rd), .i_exmem_regwrite(exmem_we),
    .i_memwb_rd(memwb_rd), .i_memwb_regwrite(memwb_we), .i_flush(flush),
    .o_id_stall(id_stall), .o_ex_valid(ex_valid), .o_ex_regwrite(ex_rw),
    .o_ex_memread(ex_mr), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd),
    .o_ex_op1(ex_op1), .o_ex_op2(ex_op2), .o_ex_imm(ex_imm), .o_ex_ctrl(ex_ctrl),
    .o_ex_fwd_a(fwd_a), .o_ex_fwd_b(fwd_b), .o_stall_count(stall_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model of the instruction currently sitting in EX
  logic             m_valid, m_rw, m_mr;
  logic [4:0]       m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0]  m_op1, m_op2, m_imm;
  logic [CTRLW-1:0] m_ctrl;
  longint unsigned  m_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_op1 = 0; m_op2 = 0; m_imm = 0; m_ctrl = 0; m_count = 0;
  endtask

  function automatic logic reads_reg(input logic [4:0] r, input logic writes);
    return writes && (r != 0) && ((use1 && rs1 == r) || (use2 && rs2 == r));
  endfunction

  function automatic logic exp_stall();
    logic hz;
    hz = reads_reg(m_rd, m_valid && m_mr);
`ifndef FORWARDING_EN
    hz = hz || reads_reg(m_rd, m_valid && m_rw) || reads_reg(exmem_rd, exmem_we);
`endif
    return id_valid && hz && !flush;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
`ifdef FORWARDING_EN
    if (!m_valid || r == 0) return 2'd0;
    if (exmem_we && exmem_rd == r) return 2'd2;
    if (memwb_we && memwb_rd == r) return 2'd1;
`endif
    return 2'd0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":ex_valid"}, ex_valid, m_valid);
    chk({tag, ":ex_regwrite"}, ex_rw, m_rw);
    chk({tag, ":ex_memread"}, ex_mr, m_mr);
    chk({tag, ":ex_rs1"}, ex_rs1, m_rs1);
    chk({tag, ":ex_rs2"}, ex_rs2, m_rs2);
    chk({tag, ":ex_rd"}, ex_rd, m_rd);
    chk({tag, ":ex_op1"}, ex_op1, m_op1);
    chk({tag, ":ex_op2"}, ex_op2, m_op2);
    chk({tag, ":ex_imm"}, ex_imm, m_imm);
    chk({tag, ":ex_ctrl"}, ex_ctrl, m_ctrl);
    chk({tag, ":fwd_a"}, fwd_a, exp_fwd(m_rs1));
    chk({tag, ":fwd_b"}, fwd_b, exp_fwd(m_rs2));
    chk({tag, ":stall_count"}, stall_count, m_count);
  endtask

  // called at a negedge with ID inputs applied; returns at the next negedge
  task automatic step(input string tag);
    logic st;
    #1;
    st = exp_stall();
    chk({tag, ":id_stall"}, id_stall, st);
    chk({tag, ":pre_fwd_a"}, fwd_a, exp_fwd(m_rs1));
    @(posedge clk);
    if (flush || st) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_op1 = 0; m_op2 = 0; m_imm = 0; m_ctrl = 0;
    end else begin
      m_valid = id_valid; m_rw = id_valid && id_rw; m_mr = id_valid && id_mr;
      m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
      m_op1 = rd1; m_op2 = rd2; m_imm = imm; m_ctrl = ctrl;
    end
    if (st && m_count != 64'hFFFF_FFFF) m_count++;
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic u1, input logic u2, input logic w,
                        input logic m, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d);
    id_valid = v; use1 = u1; use2 = u2; id_rw = w; id_mr = m;
    rs1 = s1; rs2 = s2; rd = d;
    imm = {$urandom, $urandom}; rd1 = {$urandom, $urandom};
    rd2 = {$urandom, $urandom}; ctrl = CTRLW'($urandom);
  endtask

  initial begin
    reset_n = 0; flush = 0;
    exmem_rd = 0; exmem_we = 0; memwb_rd = 0; memwb_we = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1;

    // load-use: lw x5 then add x6,x5,x7
    set_id(1, 1, 0, 1, 1, 2, 0, 5);
    step("lw_load");
    set_id(1, 1, 1, 1, 0, 5, 7, 6);
    step("lu_stall");
    chk("lu_bubble_valid", ex_valid, 1'b0);
    step("lu_advance");
    chk("lu_add_in_ex", ex_rd, 5'd6);
    chk("lu_count_one", stall_count, 32'd1);

    // forwarding priority with ex_rs1 = x5 (add x6 is in EX)
    exmem_rd = 5; exmem_we = 1; memwb_rd = 5; memwb_we = 1;
    #1;
`ifdef FORWARDING_EN
    chk("fwd_exmem_prio", fwd_a, 2'b10);
    exmem_we = 0; #1;
    chk("fwd_memwb", fwd_a, 2'b01);
`else
    chk("fwd_tied_zero", fwd_a, 2'b00);
`endif
    exmem_we = 0; memwb_we = 0;
    @(negedge clk);

    // x0 never matches, even against a load to x0
    set_id(1, 1, 0, 1, 1, 0, 0, 0);
    step("x0_load");
    set_id(1, 1, 1, 1, 0, 0, 0, 9);
    exmem_rd = 0; exmem_we = 1;
    step("x0_use");
    exmem_we = 0;
    chk("x0_fwd_a", fwd_a, 2'b00);

    // load-use coinciding with flush: no stall, bubble, count unchanged
    set_id(1, 1, 0, 1, 1, 1, 0, 5);
    step("fl_load");
    set_id(1, 1, 0, 1, 0, 5, 0, 8);
    flush = 1;
    step("fl_flush");
    flush = 0;
    chk("fl_no_count", stall_count, 32'd1);

`ifndef FORWARDING_EN
    // ALU producer x3 stalls twice (in EX, then in MEM)
    set_id(1, 0, 0, 1, 0, 0, 0, 3);
    step("alu_prod");
    set_id(1, 1, 0, 1, 0, 3, 0, 4);
    step("alu_stall_ex");
    exmem_rd = 3; exmem_we = 1;
    step("alu_stall_mem");
    exmem_we = 0;
    step("alu_advance");
    chk("alu_count", stall_count, 32'd3);
`endif

    // async reset in the middle of a load-use stall
    set_id(1, 1, 0, 1, 1, 1, 0, 5);
    step("rst_load");
    chk("rst_pre_valid", ex_valid, 1'b1);
    set_id(1, 1, 0, 1, 0, 5, 0, 8);
    #2 reset_n = 0;
    #1 model_clear();
    check_all("rst_async");
    reset_n = 1;
    @(negedge clk);
    step("rst_first_edge");

    // randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)));
      exmem_rd = 5'($urandom_range(0, 7)); exmem_we = 1'($urandom);
      memwb_rd = 5'($urandom_range(0, 7)); memwb_we = 1'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
